dc_wr_buffer: RTL



---
 rtl/dc_pkg.sv | 21 ++
 rtl/dc_wrbuf_cam.sv | 25 ++
 rtl/dc_wr_buffer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dc_pkg.sv
// Shared types for the dcache write path: default geometry, sequencer state
// encoding and the buffered-store record.
package dc_pkg;

    localparam int DC_DEPTH    = 4;
    localparam int DC_ADDR_W   = 32;
    localparam int DC_DATA_W   = 32;
    localparam int DC_LINE_OFF = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WRITING = 1'b1
    } wr_state_e;

    typedef struct packed {
        logic [DC_ADDR_W-1:0]   addr;
        logic [DC_DATA_W-1:0]   data;
        logic [DC_DATA_W/8-1:0] be;
    } dc_entry_t;

endpackage

// File: rtl/dc_wrbuf_cam.sv
// DEPTH-way line-address comparator with valid masking; one hit bit per entry
// so the same block can later drive store-to-load forwarding.
module dc_wrbuf_cam
    import dc_pkg::*;
#(
    parameter int DEPTH    = DC_DEPTH,
    parameter int ADDR_W   = DC_ADDR_W,
    parameter int LINE_OFF = DC_LINE_OFF
) (
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [ADDR_W-1:0] addr_i [DEPTH],
    input  logic [ADDR_W-1:0] key_i,
    output logic [DEPTH-1:0]  hit_vec_o
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        hit_vec_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec_o[i] = valid_i[i] &&
                           (addr_i[i][ADDR_W-1:LINE_OFF] == key_i[ADDR_W-1:LINE_OFF]);
        end
    end

endmodule

// File: rtl/dc_wr_buffer.sv
// Store write buffer and write sequencer between writeback and the dcache
// arbiter: queues committed stores and holds the oldest stable until written.
module dc_wr_buffer
    import dc_pkg::*;
#(
    parameter int DEPTH    = DC_DEPTH,
    parameter int ADDR_W   = DC_ADDR_W,
    parameter int DATA_W   = DC_DATA_W,
    parameter int LINE_OFF = DC_LINE_OFF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [ADDR_W-1:0]   push_addr,
    input  logic [DATA_W-1:0]   push_data,
    input  logic [DATA_W/8-1:0] push_be,
    output logic                push_stall,
    input  logic                v_mem_read,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic                wen,
    input  logic                mem_wr_done,
    output logic                wr_fifo_empty,
    output logic                wr_fifo_to_be_full,
    output logic                mem_conflict,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W/8-1:0] wr_be,
    output logic                wr_busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int BE_W  = DATA_W / 8;
    localparam logic [PTR_W-1:0] FULL_CNT   = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ALMOST_CNT = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [BE_W-1:0]   be_q   [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q, tail_q, count_q, count_d;
    wr_state_e         state_q, state_d;

    logic [IDX_W-1:0]  head_idx, tail_idx;
    logic              push_ok, pop;
    logic [DEPTH-1:0]  cam_hit_vec;
    logic              push_line_hit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_idx = IDX_W'(head_q);
    assign tail_idx = IDX_W'(tail_q);

    // A push arriving while full is dropped even if the head pops this cycle.
    assign push_ok = push && (count_q != FULL_CNT);
    assign pop     = (state_q == ST_WRITING) && mem_wr_done;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + PTR_W'(1);
            2'b01:   count_d = count_q - PTR_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            // NOTE: entries are reset because the head outputs read them directly and must be 0 out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            if (push_ok) begin
                addr_q[tail_idx]  <= push_addr;
                data_q[tail_idx]  <= push_data;
                be_q[tail_idx]    <= push_be;
                valid_q[tail_idx] <= 1'b1;
                tail_q            <= ptr_inc(tail_q);
            end
            if (pop) begin
                valid_q[head_idx] <= 1'b0;
                head_q            <= ptr_inc(head_q);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (wen && (count_q != '0)) state_d = ST_WRITING;
            ST_WRITING: if (mem_wr_done)            state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_busy            = (state_q == ST_WRITING);
        wr_fifo_empty      = (count_q == '0);
        wr_fifo_to_be_full = (count_q >= ALMOST_CNT);
        push_stall         = (count_q == FULL_CNT);
        wr_addr            = addr_q[head_idx];
        wr_data            = data_q[head_idx];
        wr_be              = be_q[head_idx];
    end

    dc_wrbuf_cam #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .LINE_OFF (LINE_OFF)
    ) u_cam (
        .valid_i   (valid_q),
        .addr_i    (addr_q),
        .key_i     (rd_addr),
        .hit_vec_o (cam_hit_vec)
    );

    // A store being accepted this cycle is not yet in the CAM but still conflicts.
    assign push_line_hit = push_ok &&
                           (push_addr[ADDR_W-1:LINE_OFF] == rd_addr[ADDR_W-1:LINE_OFF]);
    assign mem_conflict  = v_mem_read && ((|cam_hit_vec) || push_line_hit);

endmodule
